gc_row_sequencer: RTL and testbench

GC_ROW_SEQUENCER -- requirements
Module: gc_row_sequencer

---
 rtl/gc_ctrl_pkg.sv | 18 +
 rtl/gc_refresh_timer.sv | 35 +++
 rtl/gc_row_sequencer.sv | 92 +++++++++
 tb/tb_gc_row_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/gc_ctrl_pkg.sv
// Shared types for the gain-cell array controller: row width, sequencer
// state encoding and the latched operation descriptor.
package gc_ctrl_pkg;
  localparam int ROW_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    PULSE   = 2'd2,
    RECOVER = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic             we;
    logic             refr;
  } row_op_t;
endpackage

// File: rtl/gc_refresh_timer.sv
// Free-running refresh interval timer; raises a sticky pending flag one edge
// after the down-counter hits zero, cleared when the sequencer starts the refresh.
module gc_refresh_timer #(
  parameter int INTERVAL = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic pending_o
);
  localparam logic [15:0] RELOAD = 16'(INTERVAL - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        pending_q, pending_d;
  logic        expire;

  always_comb begin
    expire    = (cnt_q == 16'd0);
    cnt_d     = expire ? RELOAD : cnt_q - 16'd1;
    // A fresh expiry wins over a same-cycle clear: it is a new interval, not a queued one.
    pending_d = expire | (pending_q & ~clr_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= RELOAD;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;
endmodule

// File: rtl/gc_row_sequencer.sv
// Row access sequencer: select settles in SETUP, wordline pulses for
// WL_PULSE_CYCLES, one RECOVER cycle; periodic refresh walks rows 0..7.
module gc_row_sequencer
  import gc_ctrl_pkg::*;
#(
  parameter int WL_PULSE_CYCLES  = 4,
  parameter int REFRESH_INTERVAL = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [ROW_W-1:0] req_row,
  output logic             wl_en,
  output logic [ROW_W-1:0] wl_sel,
  output logic             wr_en,
  output logic             refresh_active,
  output logic             done
);
  localparam logic [3:0] PULSE_LAST = 4'(WL_PULSE_CYCLES - 1);

  seq_state_e       state_q, state_d;
  row_op_t          op_q, op_d;
  logic [3:0]       pcnt_q, pcnt_d;
  logic [ROW_W-1:0] ptr_q, ptr_d;
  logic             ref_pending;
  logic             start_ref;

  gc_refresh_timer #(.INTERVAL(REFRESH_INTERVAL)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (start_ref),
    .pending_o (ref_pending)
  );

  assign req_ready = (state_q == IDLE) && !ref_pending && !rst;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    pcnt_d    = pcnt_q;
    ptr_d     = ptr_q;
    start_ref = 1'b0;
    case (state_q)
      IDLE: begin
        if (ref_pending) begin
          state_d   = SETUP;
          op_d      = '{row: ptr_q, we: 1'b0, refr: 1'b1};
          start_ref = 1'b1;
        end else if (req_valid && req_ready) begin
          state_d = SETUP;
          op_d    = '{row: req_row, we: req_we, refr: 1'b0};
        end
      end
      SETUP: begin
        state_d = PULSE;
        pcnt_d  = PULSE_LAST;
      end
      PULSE: begin
        if (pcnt_q == 4'd0) state_d = RECOVER;
        else                pcnt_d  = pcnt_q - 4'd1;
      end
      RECOVER: begin
        state_d = IDLE;
        if (op_q.refr) ptr_d = ptr_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      pcnt_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pcnt_q  <= pcnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // wl_sel is the latched row, so it also holds its last value through IDLE.
  assign wl_sel         = op_q.row;
  assign wl_en          = (state_q == PULSE);
  assign wr_en          = wl_en && op_q.we && !op_q.refr;
  assign done           = (state_q == RECOVER) && !op_q.refr;
  assign refresh_active = (state_q != IDLE) && op_q.refr;
endmodule

// File: tb/tb_gc_row_sequencer.sv
// Directed bench for gc_row_sequencer: stimulus pushes expected operations,
// a negedge monitor reconstructs each wordline pulse and checks it on RECOVER.
module tb_gc_row_sequencer;
  localparam int WL = 4;
  localparam int RI = 16;

  typedef struct {
    bit         is_ref;
    logic [2:0] row;
    bit         we;
    int         t_end;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_we;
  logic [2:0] req_row, wl_sel;
  logic       wl_en, wr_en, refresh_active, done;

  int   total = 0;
  int   bad   = 0;
  int   cyc;
  exp_t q[$];

  gc_row_sequencer #(.WL_PULSE_CYCLES(WL), .REFRESH_INTERVAL(RI)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_row        (req_row),
    .wl_en          (wl_en),
    .wl_sel         (wl_sel),
    .wr_en          (wr_en),
    .refresh_active (refresh_active),
    .done           (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", name, got, want, cyc);
    end
  endtask

  task automatic expect_op(input bit is_ref, input logic [2:0] row, input bit we, input int t_end);
    exp_t e;
    e.is_ref = is_ref; e.row = row; e.we = we; e.t_end = t_end;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    int n = 0;
    while (cyc < c && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_cyc_reached", int'(cyc >= c), 1);
  endtask

  // Hold a request until accepted; the accept cycle is the one where ready is seen.
  task automatic issue(input logic [2:0] row, input logic we, input bit track, input int exp_acc);
    int n = 0;
    req_valid = 1'b1; req_row = row; req_we = we;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_cycle", cyc, exp_acc);
    if (req_ready && track) expect_op(1'b0, row, we, cyc + 2 + WL);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Monitor: an operation ends on the first cycle wl_en drops (RECOVER).
  bit         prev_wl, prev_ra, op_ref, sel_ok;
  logic [2:0] prev_sel, op_row;
  int         pulses, wrs;

  always @(negedge clk) begin
    if (rst) begin
      prev_wl = 1'b0; prev_ra = 1'b0; prev_sel = wl_sel;
    end else begin
      chk("done_only_in_recover", int'(done && !(prev_wl && !wl_en)), 0);
      chk("wr_en_only_with_wl_en", int'(wr_en && !wl_en), 0);
      if (wl_en && !prev_wl) begin
        op_row = wl_sel; op_ref = refresh_active; pulses = 0; wrs = 0;
        sel_ok = (prev_sel == wl_sel) && (prev_ra == refresh_active);
      end
      if (wl_en) begin
        pulses++;
        wrs += int'(wr_en);
        if (wl_sel != op_row || refresh_active != op_ref) sel_ok = 1'b0;
      end
      if (prev_wl && !wl_en) begin
        chk("op_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          chk("op_is_refresh", int'(op_ref), int'(e.is_ref));
          chk("op_row", int'(op_row), int'(e.row));
          chk("wl_pulse_len", pulses, WL);
          chk("wr_en_cycles", wrs, e.we ? WL : 0);
          chk("done_at_recover", int'(done), int'(!e.is_ref));
          chk("ref_active_recover", int'(refresh_active), int'(e.is_ref));
          chk("wl_sel_held_recover", int'(wl_sel), int'(e.row));
          chk("sel_stable_setup_pulse", int'(sel_ok), 1);
          chk("recover_cycle", cyc, e.t_end);
        end
      end
      prev_wl = wl_en; prev_sel = wl_sel; prev_ra = refresh_active;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_row = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_wl_en", wl_en, 0);
    chk("rst_wl_sel", wl_sel, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_done", done, 0);
    chk("rst_ref_active", refresh_active, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);

    // First refresh on row 0, then a read of row 5.
    expect_op(1'b1, 3'd0, 1'b0, 22);
    wait_cyc(24);
    issue(3'd5, 1'b0, 1'b1, 24);
    wait_cyc(31);
    chk("ready_after_read", req_ready, 1);
    chk("wl_sel_hold_idle", wl_sel, 5);

    // Write of row 2 between refreshes.
    expect_op(1'b1, 3'd1, 1'b0, 38);
    wait_cyc(40);
    issue(3'd2, 1'b1, 1'b1, 40);

    // Request raised in the cycle a refresh becomes pending: refresh goes first.
    expect_op(1'b1, 3'd2, 1'b0, 54);
    expect_op(1'b1, 3'd3, 1'b0, 70);
    wait_cyc(64);
    issue(3'd6, 1'b0, 1'b1, 71);

    // Accept in the same cycle the counter expires: user access completes first.
    wait_cyc(79);
    issue(3'd7, 1'b1, 1'b1, 79);
    expect_op(1'b1, 3'd4, 1'b0, 92);
    expect_op(1'b1, 3'd5, 1'b0, 102);
    expect_op(1'b1, 3'd6, 1'b0, 118);
    expect_op(1'b1, 3'd7, 1'b0, 134);
    expect_op(1'b1, 3'd0, 1'b0, 150);

    // Reset during the third wordline cycle of a write.
    wait_cyc(152);
    issue(3'd3, 1'b1, 1'b0, 152);
    wait_cyc(156);
    chk("third_pulse_wl_en", wl_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_wl_en", wl_en, 0);
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_wl_sel", wl_sel, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ref_active", refresh_active, 0);
    chk("midrst_req_ready", req_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_midrst", req_ready, 1);
    expect_op(1'b1, 3'd0, 1'b0, 22);
    wait_cyc(30);
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
